hs4_responder: RTL and testbench

- Destination-end responder for a 4-phase req/ack handshake carrying a data word.
- Runs entirely in the receiving clock domain. Synchronises the asynchronous `req_in`, captures `data_in`, and hands the word to a local consumer over valid/ready.
- Returns a registered, glitch-free `ack_out` level to the sender.
- Pairs with any source-side requester that holds `data_in` stable from req rise until ack is seen.

---
 rtl/hs4_responder_if.sv | 27 ++
 rtl/hs4_responder.sv | 120 ++++++++++++
 tb/tb_hs4_responder.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hs4_responder_if.sv
// Bundle between a 4-phase req/ack sender, the hs4_responder and its local consumer.
// master = sender/consumer side, slave = responder side.
interface hs4_responder_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned CNT_W  = 8
);
   logic              req_in;
   logic [DATA_W-1:0] data_in;
   logic              ack_out;
   logic [DATA_W-1:0] dout;
   logic              dout_valid;
   logic              dout_ready;
   logic              busy;
   logic [CNT_W-1:0]  xfer_cnt;
   logic              proto_err;
   logic              timeout_err;

   modport master (
      output req_in, data_in, dout_ready,
      input  ack_out, dout, dout_valid, busy, xfer_cnt, proto_err, timeout_err
   );

   modport slave (
      input  req_in, data_in, dout_ready,
      output ack_out, dout, dout_valid, busy, xfer_cnt, proto_err, timeout_err
   );
endinterface

// File: rtl/hs4_responder.sv
// Destination end of a 4-phase req/ack handshake: synchronises req, captures data, delivers
// it over valid/ready and returns a registered ack. Optional WAIT_LOW timeout: HS4_TIMEOUT_EN.
module hs4_responder #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned CNT_W       = 8,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input logic            clk,
   input logic            rst,
   hs4_responder_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StDeliver, StWaitLow, StDrain} state_e;

   state_e                  r_state;
   logic [SYNC_STAGES-1:0]  r_sync;
   logic                    w_req_sync;
   logic                    r_ack;
   logic [DATA_W-1:0]       r_dout;
   logic                    r_dout_valid;
   logic [CNT_W-1:0]        r_xfer_cnt;
   logic                    r_proto_err;

   // Only this chain ever looks at the asynchronous req_in.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], bus.req_in};
      end
   end

   assign w_req_sync = r_sync[SYNC_STAGES-1];

`ifdef HS4_TIMEOUT_EN
   localparam int unsigned TcntW = $clog2(TIMEOUT_CYC + 1);

   logic             r_timeout_err;
   logic [TcntW-1:0] r_tcnt;
   logic [TcntW-1:0] w_tcnt_nxt;

   assign w_tcnt_nxt      = r_tcnt + TcntW'(1);
   assign bus.timeout_err = r_timeout_err;
`else
   logic w_unused_timeout;

   assign w_unused_timeout = ^TIMEOUT_CYC;
   assign bus.timeout_err  = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= StIdle;
         r_ack        <= 1'b0;
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
         r_xfer_cnt   <= '0;
         r_proto_err  <= 1'b0;
`ifdef HS4_TIMEOUT_EN
         r_timeout_err <= 1'b0;
         r_tcnt        <= '0;
`endif
      end else begin
         case (r_state)
            StIdle: begin
               if (w_req_sync) begin
                  r_dout       <= bus.data_in;
                  r_dout_valid <= 1'b1;
                  r_state      <= StDeliver;
               end
            end
            StDeliver: begin
               // Early req drop is flagged but the held word is still delivered.
               if (!w_req_sync) begin
                  r_proto_err <= 1'b1;
               end
               if (r_dout_valid && bus.dout_ready) begin
                  r_dout_valid <= 1'b0;
                  r_ack        <= 1'b1;
                  r_xfer_cnt   <= r_xfer_cnt + CNT_W'(1);
                  r_state      <= StWaitLow;
`ifdef HS4_TIMEOUT_EN
                  r_tcnt       <= '0;
`endif
               end
            end
            StWaitLow: begin
               if (!w_req_sync) begin
                  r_ack   <= 1'b0;
                  r_state <= StIdle;
               end
`ifdef HS4_TIMEOUT_EN
               else if (w_tcnt_nxt == TcntW'(TIMEOUT_CYC)) begin
                  r_timeout_err <= 1'b1;
                  r_ack         <= 1'b0;
                  r_state       <= StDrain;
               end else begin
                  r_tcnt <= w_tcnt_nxt;
               end
`endif
            end
            StDrain: begin
               if (!w_req_sync) begin
                  r_state <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign bus.ack_out    = r_ack;
   assign bus.dout       = r_dout;
   assign bus.dout_valid = r_dout_valid;
   assign bus.xfer_cnt   = r_xfer_cnt;
   assign bus.proto_err  = r_proto_err;
   assign bus.busy       = (r_state != StIdle);

endmodule

// File: tb/tb_hs4_responder.sv
// Scoreboard bench for hs4_responder: driver pushes expected words, a negedge monitor pops
// and compares on every accepted delivery. Timeout section runs only with HS4_TIMEOUT_EN.
module tb_hs4_responder;

   localparam int unsigned DATA_W      = 8;
   localparam int unsigned SYNC_STAGES = 2;
   localparam int unsigned CNT_W       = 8;
   localparam int unsigned TIMEOUT_CYC = 16;

   logic clk;
   logic rst;

   hs4_responder_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

   hs4_responder #(
      .DATA_W      (DATA_W),
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int unsigned       n_checks = 0;
   int unsigned       n_fail   = 0;
   logic [DATA_W-1:0] exp_q[$];
   logic [CNT_W-1:0]  exp_cnt  = '0;
   bit                exp_proto = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every accepted delivery must match the oldest issued word, in order.
   always @(negedge clk) begin
      if (!rst && bus.dout_valid === 1'b1 && bus.dout_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected: got word 0x%0h, expected none", bus.dout);
         end else begin
            check("sb_dout", 32'(bus.dout), 32'(exp_q.pop_front()));
            check("sb_cnt_before", 32'(bus.xfer_cnt), 32'(exp_cnt));
            exp_cnt = exp_cnt + 1'b1;
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      bus.req_in = 1'b0;
      bus.dout_ready = 1'b0;
      exp_q.delete();
      exp_cnt = '0;
      exp_proto = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // One full 4-phase transfer; early=1 drops req while still in DELIVER (delay must be >=3).
   task automatic xfer(input logic [DATA_W-1:0] d, input int delay, input bit early);
      int n;
      bit ok;
      exp_q.push_back(d);
      bus.data_in    = d;
      bus.req_in     = 1'b1;
      bus.dout_ready = (delay == 0) && !early;
      n = 0;
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         n++;
         if (bus.dout_valid) begin
            ok = 1'b1;
            break;
         end
      end
      check("valid_latency", n, SYNC_STAGES + 1);
      if (!ok) begin
         bus.req_in = 1'b0;
         return;
      end
      check("capture_dout", 32'(bus.dout), 32'(d));
      if (early) begin
         bus.req_in = 1'b0;
         exp_proto  = 1'b1;
      end
      for (int i = 0; i < delay; i++) begin
         @(posedge clk);
         #1;
         check("bp_ack_low", bus.ack_out, 0);
         check("bp_valid", bus.dout_valid, 1);
         check("bp_dout_hold", 32'(bus.dout), 32'(d));
      end
      bus.dout_ready = 1'b1;
      @(posedge clk);
      #1;
      check("ack_rise", bus.ack_out, 1);
      check("valid_fall", bus.dout_valid, 0);
      check("xfer_cnt", 32'(bus.xfer_cnt), 32'(exp_cnt));
      bus.dout_ready = 1'($urandom_range(0, 1));
      if (early) begin
         @(posedge clk);
         #1;
         check("ack_pulse_1cyc", bus.ack_out, 0);
      end else begin
         bus.req_in = 1'b0;
         n = 0;
         for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (!bus.ack_out) break;
         end
         check("ack_fall_latency", n, SYNC_STAGES + 1);
      end
      check("idle_busy", bus.busy, 0);
      check("proto_err", bus.proto_err, 32'(exp_proto));
      check("timeout_err", bus.timeout_err, 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      bit ok;
      rst = 1'b1;
      bus.req_in = 1'b0;
      bus.data_in = '0;
      bus.dout_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ack", bus.ack_out, 0);
      check("rst_valid", bus.dout_valid, 0);
      check("rst_dout", 32'(bus.dout), 0);
      check("rst_busy", bus.busy, 0);
      check("rst_cnt", 32'(bus.xfer_cnt), 0);
      check("rst_proto", bus.proto_err, 0);
      check("rst_timeout", bus.timeout_err, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      xfer(8'hA5, 0, 1'b0);
      check("basic_cnt_one", 32'(bus.xfer_cnt), 1);
      xfer(8'h3C, 10, 1'b0);
      xfer(8'h5A, 4, 1'b1);

      for (int i = 0; i < 30; i++) begin
         bit e;
         e = 1'($urandom_range(0, 3) == 0);
         xfer(8'($urandom), e ? int'($urandom_range(3, 5)) : int'($urandom_range(0, 4)), e);
      end

      // Reset while parked in WAIT_LOW with req still high.
      exp_q.push_back(8'h77);
      bus.data_in = 8'h77;
      bus.req_in = 1'b1;
      bus.dout_ready = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (bus.ack_out) begin
            ok = 1'b1;
            break;
         end
      end
      check("mid_reach_waitlow", ok, 1);
      #2;
      rst = 1'b1;
      #1;
      check("async_ack", bus.ack_out, 0);
      check("async_valid", bus.dout_valid, 0);
      check("async_busy", bus.busy, 0);
      check("async_cnt", 32'(bus.xfer_cnt), 0);
      check("async_proto", bus.proto_err, 0);
      bus.req_in = 1'b0;
      exp_q.delete();
      exp_cnt = '0;
      exp_proto = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      xfer(8'h11, 1, 1'b0);
      check("post_rst_cnt", 32'(bus.xfer_cnt), 1);

      do_reset();
      for (int i = 0; i < 256; i++) begin
         xfer(8'(i), int'($urandom_range(0, 2)), 1'b0);
      end
      check("wrap_cnt", 32'(bus.xfer_cnt), 0);

`ifdef HS4_TIMEOUT_EN
      do_reset();
      exp_q.push_back(8'hC3);
      bus.data_in = 8'hC3;
      bus.req_in = 1'b1;
      bus.dout_ready = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (bus.ack_out) begin
            ok = 1'b1;
            break;
         end
      end
      check("to_ack_rise", ok, 1);
      n = 0;
      for (int i = 0; i < int'(TIMEOUT_CYC) + 5; i++) begin
         @(posedge clk);
         #1;
         n++;
         if (bus.timeout_err) break;
      end
      check("to_latency", n, TIMEOUT_CYC);
      check("to_err", bus.timeout_err, 1);
      check("to_ack_low", bus.ack_out, 0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("drain_no_capture", bus.dout_valid, 0);
         check("drain_busy", bus.busy, 1);
      end
      check("to_cnt", 32'(bus.xfer_cnt), 1);
      bus.req_in = 1'b0;
      repeat (SYNC_STAGES + 1) @(posedge clk);
      #1;
      check("drain_to_idle", bus.busy, 0);
      bus.data_in = 8'h42;
      exp_q.push_back(8'h42);
      bus.req_in = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (bus.ack_out) begin
            ok = 1'b1;
            break;
         end
      end
      check("to_next_xfer", ok, 1);
      check("to_next_cnt", 32'(bus.xfer_cnt), 2);
      check("to_err_sticky", bus.timeout_err, 1);
      bus.req_in = 1'b0;
      repeat (SYNC_STAGES + 2) @(posedge clk);
      #1;
`endif

      check("sb_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
